// File: rtl/temp_sample_ctrl_if.sv
// ============================================================================
// Module   : temp_sample_ctrl_if
// Purpose  : Signal bundle between temp_sample_ctrl, its I2C master and its user.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface temp_sample_ctrl_if;
    logic        enable;
    logic        err_clr;
    logic        i2c_start;
    logic        i2c_busy;
    logic [15:0] i2c_data;
    logic        i2c_valid;
    logic [11:0] temp_raw;
    logic [11:0] temp_avg;
    logic        sample_valid;
    logic        alarm;
    logic        timeout_err;
    logic [15:0] sample_count;

    // The controller block itself
    modport slave (
        input  enable, err_clr, i2c_busy, i2c_data, i2c_valid,
        output i2c_start, temp_raw, temp_avg, sample_valid, alarm,
               timeout_err, sample_count
    );

    // The surrounding environment (I2C master model and user logic)
    modport master (
        output enable, err_clr, i2c_busy, i2c_data, i2c_valid,
        input  i2c_start, temp_raw, temp_avg, sample_valid, alarm,
               timeout_err, sample_count
    );
endinterface

`default_nettype wire

// File: rtl/temp_sample_ctrl.sv
// ============================================================================
// Module   : temp_sample_ctrl
// Purpose  : Polls an I2C temperature sensor, box-car averages the readings,
//            and drives a hysteresis alarm, sample counter and timeout flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module temp_sample_ctrl #(
    parameter int                 POLL_DIV    = 10_000_000,
    parameter int                 TIMEOUT_CYC = 200_000,
    parameter int                 AVG_LOG2    = 3,
    parameter logic signed [11:0] HI_THRESH   = 12'sd400,
    parameter logic signed [11:0] LO_THRESH   = 12'sd384
) (
    input  logic                clk,
    input  logic                reset,
    temp_sample_ctrl_if.slave   bus
);

    localparam int c_DEPTH  = 1 << AVG_LOG2;
    localparam int c_SUM_W  = 12 + AVG_LOG2;
    localparam int c_POLL_W = $clog2(POLL_DIV + 1);
    localparam int c_TO_W   = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_UPDATE    = 3'd3,
        S_WAIT_TICK = 3'd4
    } state_t;

    state_t                     r_state;
    logic [c_POLL_W-1:0]        r_poll_cnt;
    logic [c_TO_W-1:0]          r_to_cnt;
    logic signed [11:0]         r_capture;
    logic signed [11:0]         r_buf [c_DEPTH];
    logic signed [c_SUM_W-1:0]  r_sum;
    logic                       r_primed;
    logic                       r_start;
    logic signed [11:0]         r_temp_raw;
    logic signed [11:0]         r_temp_avg;
    logic                       r_sample_valid;
    logic                       r_alarm;
    logic                       r_timeout_err;
    logic [15:0]                r_sample_count;

    logic signed [c_SUM_W-1:0]  w_samp_ext;
    logic signed [c_SUM_W-1:0]  w_oldest_ext;
    logic signed [c_SUM_W-1:0]  w_sum_next;
    logic signed [11:0]         w_avg_next;
    logic                       w_unused_lsbs;

    // The sensor's low nibble carries no temperature information
    assign w_unused_lsbs = ^bus.i2c_data[3:0];

    assign w_samp_ext   = c_SUM_W'(r_capture);
    assign w_oldest_ext = c_SUM_W'(r_buf[c_DEPTH-1]);

    // Unprimed: pretend the whole window already holds this sample
    assign w_sum_next = r_primed ? (r_sum + w_samp_ext - w_oldest_ext)
                                 : (w_samp_ext <<< AVG_LOG2);
    assign w_avg_next = 12'(w_sum_next >>> AVG_LOG2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_poll_cnt     <= '0;
            r_to_cnt       <= '0;
            r_capture      <= '0;
            r_sum          <= '0;
            r_primed       <= 1'b0;
            r_start        <= 1'b0;
            r_temp_raw     <= '0;
            r_temp_avg     <= '0;
            r_sample_valid <= 1'b0;
            r_alarm        <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_sample_count <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_start        <= 1'b0;
            r_sample_valid <= 1'b0;
            if (bus.err_clr) begin
                r_timeout_err <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_poll_cnt <= '0;
                    r_to_cnt   <= '0;
                    if (bus.enable) begin
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (!bus.i2c_busy) begin
                        r_start  <= 1'b1;
                        r_to_cnt <= '0;
                        r_state  <= S_WAIT_DATA;
                    end
                end

                S_WAIT_DATA: begin
                    if (bus.i2c_valid) begin
                        r_capture <= bus.i2c_data[15:4];
                        r_state   <= S_UPDATE;
                    end else if (r_to_cnt == c_TO_W'(TIMEOUT_CYC)) begin
                        // Later assignment overrides a same-cycle err_clr
                        r_timeout_err <= 1'b1;
                        r_poll_cnt    <= '0;
                        r_state       <= S_WAIT_TICK;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_W'(1);
                    end
                end

                S_UPDATE: begin
                    r_temp_raw     <= r_capture;
                    r_temp_avg     <= w_avg_next;
                    r_sum          <= w_sum_next;
                    r_primed       <= 1'b1;
                    r_sample_count <= r_sample_count + 16'd1;
                    r_sample_valid <= 1'b1;
                    if (!r_primed) begin
                        for (int i = 0; i < c_DEPTH; i++) begin
                            r_buf[i] <= r_capture;
                        end
                    end else begin
                        r_buf[0] <= r_capture;
                        for (int i = 1; i < c_DEPTH; i++) begin
                            r_buf[i] <= r_buf[i-1];
                        end
                    end
                    if (w_avg_next >= HI_THRESH) begin
                        r_alarm <= 1'b1;
                    end else if (w_avg_next < LO_THRESH) begin
                        r_alarm <= 1'b0;
                    end
                    r_poll_cnt <= '0;
                    r_state    <= S_WAIT_TICK;
                end

                S_WAIT_TICK: begin
                    if (!bus.enable) begin
                        r_poll_cnt <= '0;
                        r_state    <= S_IDLE;
                    end else if (r_poll_cnt == c_POLL_W'(POLL_DIV - 1)) begin
                        r_poll_cnt <= '0;
                        r_state    <= S_START;
                    end else begin
                        r_poll_cnt <= r_poll_cnt + c_POLL_W'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.i2c_start    = r_start;
    assign bus.temp_raw     = r_temp_raw;
    assign bus.temp_avg     = r_temp_avg;
    assign bus.sample_valid = r_sample_valid;
    assign bus.alarm        = r_alarm;
    assign bus.timeout_err  = r_timeout_err;
    assign bus.sample_count = r_sample_count;

endmodule

`default_nettype wire

// File: tb/tb_temp_sample_ctrl.sv
// ============================================================================
// Module   : tb_temp_sample_ctrl
// Purpose  : Directed self-checking bench for temp_sample_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_temp_sample_ctrl;

    localparam int P = 20;
    localparam int T = 50;
    localparam int L = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    temp_sample_ctrl_if bus ();

    temp_sample_ctrl #(
        .POLL_DIV    (P),
        .TIMEOUT_CYC (T),
        .AVG_LOG2    (L),
        .HI_THRESH   (12'sd400),
        .LO_THRESH   (12'sd384)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Returns the number of negedges until i2c_start is seen, or -1 on timeout
    task automatic wait_start(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (bus.i2c_start === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    // Master model: optionally wait for start, return one reading, stop at the
    // negedge where the resulting sample_valid should be visible
    task automatic feed(input logic [15:0] d, input bit wait_first, output bit ok);
        int c;
        ok = 1'b1;
        if (wait_first) begin
            wait_start(c);
            if (c < 0) begin
                ok = 1'b0;
                return;
            end
        end
        @(negedge clk);
        bus.i2c_valid = 1'b1;
        bus.i2c_data  = d;
        @(negedge clk);
        bus.i2c_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.err_clr = 1'b0;
        bus.i2c_valid = 1'b0;
        bus.i2c_busy = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.err_clr = 1'b0;
        bus.i2c_busy = 1'b0;
        bus.i2c_valid = 1'b0;
        bus.i2c_data = 16'h0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.i2c_start, bus.sample_valid, bus.alarm, bus.timeout_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.i2c_start, bus.sample_valid, bus.alarm, bus.timeout_err});
        end
        n_tests++;
        if ({bus.temp_raw, bus.temp_avg, bus.sample_count} !== 40'h0) begin
            n_fail++;
            $display("FAIL reset_data: got raw=%h avg=%h cnt=%h want 0",
                     bus.temp_raw, bus.temp_avg, bus.sample_count);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.i2c_start !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_start: got %b want 0", bus.i2c_start);
        end
    endtask

    task automatic test_prime();
        bit ok;
        int c;
        @(negedge clk);
        bus.enable = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.i2c_start !== 1'b0) begin
            n_fail++;
            $display("FAIL prime_start_n1: got %b want 0", bus.i2c_start);
        end
        @(negedge clk);
        n_tests++;
        if (bus.i2c_start !== 1'b1) begin
            n_fail++;
            $display("FAIL prime_start_n2: got %b want 1", bus.i2c_start);
        end
        @(negedge clk);
        n_tests++;
        if (bus.i2c_start !== 1'b0) begin
            n_fail++;
            $display("FAIL prime_start_width: got %b want 0", bus.i2c_start);
        end
        feed(16'h1900, 1'b0, ok);
        n_tests++;
        if ({bus.sample_valid, bus.alarm, bus.temp_raw, bus.temp_avg, bus.sample_count}
            !== {1'b1, 1'b1, 12'd400, 12'd400, 16'd1}) begin
            n_fail++;
            $display("FAIL prime_sample: got v=%b al=%b raw=%0d avg=%0d cnt=%0d want 1 1 400 400 1",
                     bus.sample_valid, bus.alarm, bus.temp_raw, bus.temp_avg, bus.sample_count);
        end
        wait_start(c);
        n_tests++;
        if (c !== 21) begin
            n_fail++;
            $display("FAIL poll_gap: got %0d cycles want 21", c);
        end
    endtask

    task automatic test_average();
        bit ok;
        logic [11:0] exp_avg [4] = '{12'd396, 12'd392, 12'd388, 12'd384};
        for (int i = 0; i < 4; i++) begin
            feed(16'h1800, (i != 0), ok);
            n_tests++;
            if (!ok || bus.sample_valid !== 1'b1 || bus.temp_raw !== 12'd384 ||
                bus.temp_avg !== exp_avg[i] || bus.alarm !== 1'b1 ||
                bus.sample_count !== 16'(i + 2)) begin
                n_fail++;
                $display("FAIL avg_step%0d: got ok=%b v=%b raw=%0d avg=%0d al=%b cnt=%0d want 1 1 384 %0d 1 %0d",
                         i, ok, bus.sample_valid, bus.temp_raw, bus.temp_avg,
                         bus.alarm, bus.sample_count, exp_avg[i], i + 2);
            end
        end
        feed(16'h17F0, 1'b1, ok);
        n_tests++;
        if (!ok || bus.temp_avg !== 12'd383 || bus.alarm !== 1'b0 ||
            bus.sample_count !== 16'd6) begin
            n_fail++;
            $display("FAIL alarm_clear: got ok=%b avg=%0d al=%b cnt=%0d want 1 383 0 6",
                     ok, bus.temp_avg, bus.alarm, bus.sample_count);
        end
    endtask

    task automatic test_negative();
        bit ok;
        do_reset();
        bus.enable = 1'b1;
        feed(16'hE700, 1'b1, ok);
        n_tests++;
        if (!ok || bus.temp_raw !== 12'hE70 || bus.temp_avg !== 12'hE70 ||
            bus.sample_count !== 16'd1 || bus.alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL neg_prime: got ok=%b raw=%h avg=%h cnt=%0d al=%b want 1 e70 e70 1 0",
                     ok, bus.temp_raw, bus.temp_avg, bus.sample_count, bus.alarm);
        end
        feed(16'hE710, 1'b1, ok);
        n_tests++;
        if (!ok || bus.temp_raw !== 12'hE71 || bus.temp_avg !== 12'hE70 ||
            bus.sample_count !== 16'd2) begin
            n_fail++;
            $display("FAIL neg_floor: got ok=%b raw=%h avg=%h cnt=%0d want 1 e71 e70 2",
                     ok, bus.temp_raw, bus.temp_avg, bus.sample_count);
        end
    endtask

    task automatic test_timeout();
        int c;
        int k_err;
        bit saw_valid;
        wait_start(c);
        n_tests++;
        if (c < 0) begin
            n_fail++;
            $display("FAIL to_first_start: got no start want start");
        end
        k_err = -1;
        saw_valid = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus.sample_valid === 1'b1) saw_valid = 1'b1;
            if (bus.timeout_err === 1'b1) begin
                k_err = k;
                break;
            end
        end
        n_tests++;
        if (k_err !== 51) begin
            n_fail++;
            $display("FAIL to_latency: got %0d cycles want 51", k_err);
        end
        n_tests++;
        if (saw_valid || bus.sample_count !== 16'd2) begin
            n_fail++;
            $display("FAIL to_discard: got valid_seen=%b cnt=%0d want 0 2",
                     saw_valid, bus.sample_count);
        end
        wait_start(c);
        n_tests++;
        if (c !== 21) begin
            n_fail++;
            $display("FAIL to_poll_gap: got %0d cycles want 21", c);
        end
        for (int k = 1; k <= 52; k++) begin
            @(negedge clk);
            if (k == 1) bus.err_clr = 1'b1;
            if (k == 2) begin
                bus.err_clr = 1'b0;
                n_tests++;
                if (bus.timeout_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL err_clr: got %b want 0", bus.timeout_err);
                end
            end
            if (k == 50) begin
                n_tests++;
                if (bus.timeout_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL to_early: got %b want 0", bus.timeout_err);
                end
                bus.err_clr = 1'b1;
            end
            if (k == 51) begin
                bus.err_clr = 1'b0;
                n_tests++;
                if (bus.timeout_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL set_wins: got %b want 1", bus.timeout_err);
                end
            end
            if (k == 52) begin
                n_tests++;
                if (bus.timeout_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL err_sticky: got %b want 1", bus.timeout_err);
                end
            end
        end
    endtask

    task automatic test_busy();
        do_reset();
        bus.i2c_busy = 1'b1;
        @(negedge clk);
        bus.enable = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.i2c_start !== (k == 9)) begin
                n_fail++;
                $display("FAIL busy_hold_k%0d: got %b want %b", k, bus.i2c_start, (k == 9));
            end
            if (k == 8) bus.i2c_busy = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int c;
        feed(16'h1900, 1'b0, ok);
        n_tests++;
        if (!ok || bus.sample_count !== 16'd1 || bus.temp_avg !== 12'd400) begin
            n_fail++;
            $display("FAIL mid_pre: got cnt=%0d avg=%0d want 1 400", bus.sample_count, bus.temp_avg);
        end
        wait_start(c);
        reset = 1'b1;
        bus.enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus.i2c_valid = 1'b1;
        bus.i2c_data  = 16'h1900;
        @(negedge clk);
        bus.i2c_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if ({bus.i2c_start, bus.sample_valid, bus.alarm, bus.timeout_err} !== 4'b0000 ||
                {bus.temp_raw, bus.temp_avg, bus.sample_count} !== 40'h0) begin
                n_fail++;
                $display("FAIL mid_ignored_k%0d: got st=%b v=%b al=%b err=%b raw=%h avg=%h cnt=%0d want all 0",
                         k, bus.i2c_start, bus.sample_valid, bus.alarm, bus.timeout_err,
                         bus.temp_raw, bus.temp_avg, bus.sample_count);
            end
        end
        bus.enable = 1'b1;
        feed(16'h1000, 1'b1, ok);
        n_tests++;
        if (!ok || bus.sample_valid !== 1'b1 || bus.temp_raw !== 12'd256 ||
            bus.temp_avg !== 12'd256 || bus.sample_count !== 16'd1 || bus.alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reprime: got ok=%b v=%b raw=%0d avg=%0d cnt=%0d al=%b want 1 1 256 256 1 0",
                     ok, bus.sample_valid, bus.temp_raw, bus.temp_avg, bus.sample_count, bus.alarm);
        end
    endtask

    initial begin
        test_reset();
        test_prime();
        test_average();
        test_negative();
        test_timeout();
        test_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
